// File: rtl/result_tx_sequencer.sv
`timescale 1ns/1ps
// result_tx_sequencer
// Latches a 32-bit result, then hands its four bytes to a UART transmitter one
// at a time with a tx_start / tx_done handshake. Supports an optional idle gap
// between bytes and an optional per-byte timeout.
// All outputs are registered. They are decoded from the next state, so each
// output already matches the state it belongs to in the cycle it appears.
module result_tx_sequencer #(
  parameter bit LSB_FIRST      = 1'b1,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic result_valid,
  input  logic tx_busy,
  input  logic tx_done,
  output logic register_result32,
  output logic send_b0,
  output logic send_b1,
  output logic send_b2,
  output logic send_b3,
  output logic tx_start,
  output logic busy,
  output logic frame_done,
  output logic overrun,
  output logic timeout_err
);

  // A single counter serves both the inter-byte gap and the byte timeout.
  // The two are never active at the same time.
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 2);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          reg_q, reg_d;
  logic [3:0]    sel_q, sel_d;
  logic          tx_start_q, tx_start_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic          timeout_err_q, timeout_err_d;
  logic [1:0]    pos_s;

  // Next-state, byte index and shared gap/timeout counter.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (result_valid) begin
          state_d = ST_LATCH;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
      ST_LOAD: begin
        // tx_start_q marks the cycle in which the start pulse is on the wire.
        if (tx_start_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WAIT: begin
        // tx_done wins over a timeout that expires in the same cycle.
        if (tx_done) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 2'd1;
            if (GAP_CYCLES != 0) begin
              state_d = ST_GAP;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST)) begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so the outputs can be registered.
  always_comb begin
    pos_s        = LSB_FIRST ? idx_d : (2'd3 - idx_d);
    reg_d        = (state_d == ST_LATCH);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
    overrun_d    = result_valid && (state_q != ST_IDLE);
    // tx_busy is sampled one cycle ahead, so the pulse itself is a flop.
    tx_start_d   = (state_d == ST_LOAD) && !tx_busy;
    if ((state_d == ST_LOAD) || (state_d == ST_WAIT)) begin
      sel_d = 4'b0001 << pos_s;
    end else begin
      sel_d = 4'b0000;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      cnt_q         <= '0;
      reg_q         <= 1'b0;
      sel_q         <= 4'b0000;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      reg_q         <= reg_d;
      sel_q         <= sel_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign register_result32 = reg_q;
  assign send_b0           = sel_q[0];
  assign send_b1           = sel_q[1];
  assign send_b2           = sel_q[2];
  assign send_b3           = sel_q[3];
  assign tx_start          = tx_start_q;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;
  assign overrun           = overrun_q;
  assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_result_tx_sequencer.sv
`timescale 1ns/1ps
// Bench for result_tx_sequencer.
// Three instances are used:
//   0: LSB first, no gap, no timeout
//   1: MSB first, gap of 3 cycles
//   2: LSB first, timeout of 20 cycles
// Each frame is planned up front as a per-cycle timeline of expected outputs
// and input stimulus. The inputs are then driven and every cycle is compared.
module tb_result_tx_sequencer;

  localparam logic [9:0] E_REG  = 10'h200;
  localparam logic [9:0] E_ST   = 10'h010;
  localparam logic [9:0] E_BUSY = 10'h008;
  localparam logic [9:0] E_DONE = 10'h004;
  localparam logic [9:0] E_OVR  = 10'h002;
  localparam logic [9:0] E_TMO  = 10'h001;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] rv_s, txb_s, txd_s;
  logic [2:0] reg_o, sb0_o, sb1_o, sb2_o, sb3_o, st_o, bz_o, fd_o, ov_o, te_o;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    result_tx_sequencer #(
      .LSB_FIRST      ((g == 1) ? 1'b0 : 1'b1),
      .GAP_CYCLES     ((g == 1) ? 3 : 0),
      .TIMEOUT_CYCLES ((g == 2) ? 20 : 0)
    ) u_dut (
      .clk               (clk),
      .reset             (reset),
      .result_valid      (rv_s[g]),
      .tx_busy           (txb_s[g]),
      .tx_done           (txd_s[g]),
      .register_result32 (reg_o[g]),
      .send_b0           (sb0_o[g]),
      .send_b1           (sb1_o[g]),
      .send_b2           (sb2_o[g]),
      .send_b3           (sb3_o[g]),
      .tx_start          (st_o[g]),
      .busy              (bz_o[g]),
      .frame_done        (fd_o[g]),
      .overrun           (ov_o[g]),
      .timeout_err       (te_o[g])
    );
  end

  function automatic logic [9:0] obs(input int d);
    return {reg_o[d], sb3_o[d], sb2_o[d], sb1_o[d], sb0_o[d],
            st_o[d], bz_o[d], fd_o[d], ov_o[d], te_o[d]};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Plan one frame on instance d, drive it cycle by cycle and compare every cycle.
  // kfix>0 fixes the tx_done latency; bforce1>=0 fixes the tx_busy stall before byte 1;
  // withhold>=0 drops tx_done on that byte; do_rst pulses reset in WAIT_DONE of byte 1.
  task automatic run_frame(input int d, input int kfix, input int bforce1, input int withhold,
                           input bit do_ovr, input bit do_rst, input logic [31:0] result,
                           input bit chk_data);
    logic [9:0] ex [0:255];
    logic       bz [0:255];
    logic       dn [0:255];
    logic       rvv[0:255];
    logic [7:0] got[$];
    logic [31:0] latched;
    logic [9:0] o;
    logic [3:0] sel;
    int gap, tmo, L, S, E, k, b, s1, rc, oc;
    bit lsb, ended, aborted;
    gap = (d == 1) ? 3 : 0;
    tmo = (d == 2) ? 20 : 0;
    lsb = (d != 1);
    for (int c = 0; c < 256; c++) begin
      ex[c] = '0; bz[c] = 1'b0; dn[c] = 1'b0; rvv[c] = 1'b0;
    end
    rvv[0] = 1'b1;
    ex[1]  = E_REG | E_BUSY;
    L = 2; E = 0; s1 = -1; ended = 1'b0;
    for (int i = 0; i < 4 && !ended; i++) begin
      b   = (i == 1 && bforce1 >= 0) ? bforce1 : int'($urandom_range(0, 2));
      k   = (kfix > 0) ? kfix : int'($urandom_range(1, 12));
      sel = 4'b0001 << (lsb ? i : 3 - i);
      for (int j = 0; j < b; j++) bz[L - 1 + j] = 1'b1;
      S = L + b;
      for (int c = L; c < S; c++) ex[c] = {1'b0, sel, 5'b0} | E_BUSY;
      ex[S] = {1'b0, sel, 5'b0} | E_ST | E_BUSY;
      if (i == 1) s1 = S;
      if (i == withhold) begin
        for (int c = S + 1; c <= S + tmo; c++) ex[c] = {1'b0, sel, 5'b0} | E_BUSY;
        E = S + tmo + 1;
        ex[E] = E_TMO;
        ended = 1'b1;
      end else begin
        for (int c = S + 1; c <= S + k; c++) ex[c] = {1'b0, sel, 5'b0} | E_BUSY;
        dn[S + k] = 1'b1;
        if (i == 3) begin
          ex[S + k + 1] = E_DONE | E_BUSY;
          E = S + k + 2;
          ex[E] = '0;
        end else begin
          for (int c = S + k + 1; c <= S + k + gap; c++) ex[c] = E_BUSY;
          L = S + k + gap + 1;
        end
      end
    end
    if (do_ovr) begin
      oc = int'($urandom_range(1, E - 1));
      rvv[oc] = 1'b1;
      ex[oc + 1] = ex[oc + 1] | E_OVR;
    end
    rc = do_rst ? s1 + 2 : -1;
    latched = '0;
    aborted = 1'b0;
    for (int c = 0; c <= E && !aborted; c++) begin
      @(posedge clk); #1;
      o = obs(d);
      check($sformatf("frame_d%0d_c%0d", d, c), 32'(o), 32'(ex[c]));
      if (o[9]) latched = result;
      if (o[4]) begin
        for (int p = 0; p < 4; p++) if (o[5 + p]) got.push_back(latched[8 * p +: 8]);
      end
      if (c == rc) begin
        #2 reset = 1'b1;
        #1 check($sformatf("async_rst_d%0d", d), 32'(obs(d)), 32'd0);
        rv_s[d] = 1'b0; txb_s[d] = 1'b0; txd_s[d] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        rv_s[d] = rvv[c]; txb_s[d] = bz[c]; txd_s[d] = dn[c];
      end
    end
    rv_s[d] = 1'b0; txb_s[d] = 1'b0; txd_s[d] = 1'b0;
    if (chk_data) begin
      check($sformatf("nbytes_d%0d", d), 32'(got.size()), 32'd4);
      for (int i = 0; i < 4 && i < got.size(); i++)
        check($sformatf("txdata_d%0d_b%0d", d, i), 32'(got[i]),
              32'(lsb ? result[8 * i +: 8] : result[8 * (3 - i) +: 8]));
    end
  endtask

  // Hard stop in case a frame never completes.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by randomized frames.
  initial begin
    int d, wh;
    reset = 1'b1; rv_s = '0; txb_s = '0; txd_s = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("rst_idle%0d", i), 32'(obs(i)), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_frame(0, 10, -1, -1, 1'b0, 1'b0, 32'h12345678, 1'b1);
    run_frame(1, 10, -1, -1, 1'b0, 1'b0, 32'h12345678, 1'b1);
    run_frame(0, 10,  5, -1, 1'b0, 1'b0, 32'hA1B2C3D4, 1'b1);
    run_frame(1,  0, -1, -1, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1);
    run_frame(2, 10, -1,  2, 1'b0, 1'b0, 32'h0, 1'b0);
    run_frame(2,  0, -1, -1, 1'b0, 1'b0, 32'h89ABCDEF, 1'b1);
    run_frame(0, 10, -1, -1, 1'b0, 1'b1, 32'h0, 1'b0);
    run_frame(0,  0, -1, -1, 1'b0, 1'b0, 32'h55AA33CC, 1'b1);

    for (int n = 0; n < 8; n++) begin
      d  = int'($urandom_range(0, 2));
      wh = (d == 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_frame(d, 0, -1, wh, 1'($urandom_range(0, 1)), 1'b0, $urandom, (wh < 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_tx_sequencer.md
Name: result_tx_sequencer

Overview:
- Controller that sequences the 32-bit result output interface onto the UART transmitter.
- Accepts a result-ready pulse and issues the latch strobe (register_result32).
- Then walks the byte selects (send_b0..send_b3) one byte at a time. Each byte is handed to the UART with a tx_start/tx_done handshake, with an optional inter-byte gap and a per-byte timeout.
- Sits between the compute core's result_valid and the output interface + UART TX pair.

Parameters:
- LSB_FIRST, 1, 1: byte order b0,b1,b2,b3; 0: b3,b2,b1,b0.
- GAP_CYCLES, 0, idle clock cycles inserted between byte completion and the next byte load (0 = none).
- TIMEOUT_CYCLES, 0, max cycles waiting for tx_done per byte (0 = timeout disabled).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- result_valid  in  1  one-cycle pulse: result_data is stable and ready to send.
- tx_busy  in  1  UART transmitter busy; tx_start must not be issued while high.
- tx_done  in  1  one-cycle pulse: UART finished the current byte.
- register_result32  out  1  latch strobe to the output interface.
- send_b0, send_b1, send_b2, send_b3  out  1 each  byte selects; one-hot or all zero.
- tx_start  out  1  one-cycle start pulse to the UART.
- busy  out  1  high from the cycle after an accepted result_valid until return to IDLE.
- frame_done  out  1  one-cycle pulse after the 4th byte completes.
- overrun  out  1  one-cycle pulse when result_valid arrives while busy; that request is dropped.
- timeout_err  out  1  one-cycle pulse when a byte times out; the frame is aborted.

Behaviour:
- Reset (async, any state): state=IDLE, byte index=0, counters=0, all outputs 0.
- Outputs are decoded from registered state/index only (Moore); no input-to-output combinational path.
- States: IDLE, LATCH, LOAD, WAIT_DONE, GAP, DONE.
- IDLE: result_valid=1 -> LATCH; byte index := 0.
- LATCH: register_result32=1 for exactly one cycle -> LOAD.
- LOAD:
  - send_bX asserted for the current byte.
  - If tx_busy=0: tx_start=1 this cycle, next state WAIT_DONE.
  - If tx_busy=1: stay in LOAD with tx_start=0 and send_bX held.
- WAIT_DONE:
  - send_bX held; timeout counter increments each cycle.
  - tx_done=1 and last byte -> DONE.
  - tx_done=1 and not last byte: index+1 -> GAP if GAP_CYCLES>0, else -> LOAD.
  - Counter reaches TIMEOUT_CYCLES (nonzero) with no tx_done: timeout_err=1, -> IDLE, no frame_done.
  - tx_done takes priority over timeout when both occur in the same cycle.
- GAP: all send_bX=0; count GAP_CYCLES cycles -> LOAD.
- DONE: frame_done=1 for one cycle -> IDLE.
- Byte mapping: index i maps to send_b(i) if LSB_FIRST=1, else send_b(3-i).
- Latency, with result_valid in cycle N while in IDLE and tx_busy=0:
  - register_result32 in N+1.
  - send_b0 and tx_start in N+2 (byte registers valid by then).
- Minimum frame length, GAP_CYCLES=0 and tx_done returning k cycles after tx_start: 2 + 4·(k+1) + 1 cycles.
- tx_done outside WAIT_DONE is ignored.
- result_valid in any state other than IDLE: overrun=1 that cycle; the in-flight frame is unaffected.
- result_valid and reset together: reset wins.
- busy is 0 in IDLE and 1 in all other states.
- Counters are wide enough for the parameter values; the timeout counter clears on each LOAD entry.

Test Plan:
- LSB_FIRST=1, GAP=0, reset, result_valid pulse, tx_done 10 cycles after each tx_start -> register_result32 at N+1; tx_start with send_b0,b1,b2,b3 in order; frame_done exactly once; busy falls to 0 the cycle after frame_done.
- LSB_FIRST=0 with the same stimulus -> select order send_b3,b2,b1,b0; with the output interface attached and result 0x12345678, tx_data sequence 0x12,0x34,0x56,0x78.
- tx_busy held high for 5 cycles on entry to LOAD for byte 1 -> send_b1 held, no tx_start during those 5 cycles; tx_start in the first cycle tx_busy=0.
- GAP_CYCLES=3 -> exactly 3 cycles with all send_bX=0 between tx_done and the next tx_start; a second result_valid mid-frame -> overrun pulse, frame completes unchanged, only one frame_done.
- TIMEOUT_CYCLES=20, tx_done withheld on byte 2 -> timeout_err pulse 20 cycles after entering WAIT_DONE, return to IDLE, no frame_done; a new result_valid then starts a full 4-byte frame.
- Assert reset in WAIT_DONE of byte 1 -> all outputs 0 immediately (asynchronous), state IDLE; after release, a frame starts from byte 0.
